// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit.
//   mdu_op_t    : 3-bit MDU operation code (6-7 reserved, treated as no-op)
//   mdu_state_t : MDU sequencer states
//   MDU_ITER    : iterations per multiply/divide
package mips_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  localparam int MDU_ITER = 32;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles from accept to result; MTHI/MTLO
// complete on the accept edge.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   start, op    : request strobe and operation (accepted in IDLE only)
//   a, b         : rs / rt operands, sampled on the accept edge
//   flush        : synchronous cancel of an in-flight operation
//   busy, done   : iterative op in progress / one-cycle completion pulse
//   hi, lo       : HI and LO registers
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MDU_ITER);
  localparam logic [CW-1:0] LAST = CW'(MDU_ITER - 1);

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // {hi-part, lo-part} working register
  logic [WIDTH-1:0]   mb_q, mb_d;     // magnitude of b
  logic [WIDTH-1:0]   a_q, a_d;       // raw dividend, needed for div-by-zero
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;   // result (product / quotient) sign
  logic               negr_q, negr_d; // remainder sign = dividend sign
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  // Operand conditioning at accept time.
  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sgn_op = (op == MULT) || (op == DIV);
  assign a_neg  = sgn_op & a[WIDTH-1];
  assign b_neg  = sgn_op & b[WIDTH-1];
  assign mag_a  = a_neg ? (~a + 1'b1) : a;
  assign mag_b  = b_neg ? (~b + 1'b1) : b;

  // Shared adder/subtractor. Multiply adds b into the upper half when the
  // current multiplier bit is set; divide subtracts b from the shifted
  // partial remainder. The top bit of alu is the "no borrow" flag on divide.
  logic [WIDTH:0]     rem_sh, lhs, rhs;
  logic [WIDTH+1:0]   alu;
  logic [2*WIDTH-1:0] iter_nx;

  always_comb begin
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    lhs    = is_div_q ? rem_sh : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    rhs    = (is_div_q || acc_q[0]) ? {1'b0, mb_q} : '0;
    alu    = {1'b0, lhs} + {1'b0, (is_div_q ? ~rhs : rhs)} + (WIDTH+2)'(is_div_q);
    if (!is_div_q)
      iter_nx = {alu[WIDTH:0], acc_q[WIDTH-1:1]};
    else if (alu[WIDTH+1])
      iter_nx = {alu[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      iter_nx = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Final sign correction.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign prod = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quo  = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem  = negr_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mb_d     = mb_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // flush wins over a same-edge start
        if (start && !flush) begin
          case (op)
            MTHI: hi_d = a;
            MTLO: lo_d = a;
            MULT, MULTU, DIV, DIVU: begin
              acc_d    = {{WIDTH{1'b0}}, mag_a};
              mb_d     = mag_b;
              a_d      = a;
              is_div_d = (op == DIV) || (op == DIVU);
              neg_d    = a_neg ^ b_neg;
              negr_d   = a_neg;
              dz_d     = (b == '0);
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = CALC;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = iter_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mb_q     <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mb_q     <= mb_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  mdu_op_t     op = MULT;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; issues a request and waits (bounded) for done.
  // lat = edge index of done (0 on timeout), bcnt = cycles busy was seen high.
  task automatic do_op(input mdu_op_t o, input logic [31:0] av, input logic [31:0] bv,
                       output int lat, output int bcnt);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
  endtask

  task automatic test_multu();
    int lat, bc;
    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++; if (lat != 33) begin errors++; $display("FAIL multu_latency got %0d exp 33", lat); end
    checks++; if (bc != 33) begin errors++; $display("FAIL multu_busy_cycles got %0d exp 33", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_fall got %b exp 0", busy); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_signed();
    int lat, bc;
    do_op(MULT, 32'hFFFF_FFFD, 32'd5, lat, bc);
    checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency got %0d exp 33", lat); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h exp fffffff1", lo); end
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
    do_op(DIV, 32'd7, 32'hFFFF_FFFE, lat, bc);  // 7 / -2 = -3 r 1
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_pos_neg_lo got %h exp fffffffd", lo); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL div_pos_neg_hi got %h exp 00000001", hi); end
  endtask

  task automatic test_div_edge();
    int lat, bc;
    do_op(DIVU, 32'd100, 32'd0, lat, bc);
    checks++; if (lat != 33) begin errors++; $display("FAIL divz_latency got %0d exp 33", lat); end
    checks++; if (hi !== 32'd100) begin errors++; $display("FAIL divz_hi got %h exp 00000064", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
    do_op(DIV, 32'hFFFF_FFF0, 32'd0, lat, bc);
    checks++; if (hi !== 32'hFFFF_FFF0) begin errors++; $display("FAIL sdivz_hi got %h exp fffffff0", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdivz_lo got %h exp ffffffff", lo); end
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo got %h exp 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divovf_hi got %h exp 00000000", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int bz = 0;
    start = 1'b1; op = MTHI; a = 32'h1234_5678;
    @(posedge clk); #1;
    if (busy || done) bz++;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
    op = MTLO; a = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0; a = '0;
    if (busy || done) bz++;
    checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_lo got %h exp 9abcdef0", lo); end
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi_kept got %h exp 12345678", hi); end
    @(posedge clk); #1;
    if (busy || done) bz++;
    checks++; if (bz != 0) begin errors++; $display("FAIL mt_busy_done got %0d exp 0", bz); end
    // reserved op code is a no-op
    start = 1'b1; op = mdu_op_t'(3'd6); a = 32'hFFFF_0000; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({busy, hi, lo} !== {1'b0, 32'h1234_5678, 32'h9ABC_DEF0}) begin
      errors++; $display("FAIL reserved_op got busy=%b hi=%h lo=%h exp busy=0 hi=12345678 lo=9abcdef0", busy, hi, lo);
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    start = 1'b1; op = MULTU; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 10) start = 1'b0;
      if (done) begin lat = k; break; end
      if (k == 9) begin start = 1'b1; op = DIVU; a = 32'd100; b = 32'd3; end
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL ignore_latency got %0d exp 33", lat); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_lo got %h exp 0000002a", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi got %h exp 00000000", hi); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_second got busy=%b exp 0", busy); end
  endtask

  task automatic test_flush();
    int dseen = 0;
    start = 1'b1; op = MTHI; a = 32'hAAAA_5555; @(posedge clk); #1;
    op = MTLO; a = 32'h1111_2222; @(posedge clk); #1;
    op = DIVU; a = 32'd100; b = 32'd7; @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    flush = 1'b1;
    @(posedge clk); #1;   // edge 15
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy); end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done || busy) dseen++;
    end
    checks++; if (dseen != 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", dseen); end
    checks++; if (hi !== 32'hAAAA_5555) begin errors++; $display("FAIL flush_hi got %h exp aaaa5555", hi); end
    checks++; if (lo !== 32'h1111_2222) begin errors++; $display("FAIL flush_lo got %h exp 11112222", lo); end
    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (hi !== 32'hAAAA_5555) begin errors++; $display("FAIL flush_prio_hi got %h exp aaaa5555", hi); end
    start = 1'b1; flush = 1'b1; op = MULTU; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_prio_busy got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat = 0, lat2 = 0;
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++; if (lat != 33 || lo !== 32'd12 || hi !== 32'd0) begin
      errors++; $display("FAIL b2b_first got lat=%0d hi=%h lo=%h exp lat=33 hi=0 lo=c", lat, hi, lo);
    end
    // issue during the done cycle: accepted at edge 34
    start = 1'b1; op = DIVU; a = 32'd50; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = k; break; end
    end
    checks++; if (lat2 != 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", lat2); end
    checks++; if (lo !== 32'd7 || hi !== 32'd1) begin
      errors++; $display("FAIL b2b_div got hi=%h lo=%h exp hi=00000001 lo=00000007", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = MTLO; a = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    op = MULTU; a = 32'hFFFF_FFFF; b = 32'h3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({hi, lo, busy} !== {32'h0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b exp all 0", hi, lo, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  initial begin
    #12 test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_multu();
    test_signed();
    test_div_edge();
    test_mthi_mtlo();
    test_ignore_start();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
